// File: rtl/cheri_dram_arbiter.sv
// cheri_dram_arbiter: shares one 65-bit SRAM port between TS-map, core data and DMA
module cheri_dram_arbiter #(
    parameter int AW   = 14,
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dat_req_i,
    output logic            dat_gnt_o,
    input  logic            dat_we_i,
    input  logic [7:0]      dat_be_i,
    input  logic [AW-1:0]   dat_addr_i,
    input  logic [64:0]     dat_wdata_i,
    output logic            dat_rvalid_o,
    output logic [64:0]     dat_rdata_o,
    input  logic            dma_req_i,
    output logic            dma_gnt_o,
    input  logic            dma_we_i,
    input  logic [7:0]      dma_be_i,
    input  logic [AW-1:0]   dma_addr_i,
    input  logic [64:0]     dma_wdata_i,
    output logic            dma_rvalid_o,
    output logic [64:0]     dma_rdata_o,
    input  logic            ts_cs_i,
    input  logic [AW-1:0]   ts_addr_i,
    output logic [64:0]     ts_rdata_o,
    output logic            mem_cs_o,
    output logic            mem_we_o,
    output logic [8:0]      mem_wmask_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [64:0]     mem_wdata_o,
    input  logic [64:0]     mem_rdata_i,
    output logic [CntW-1:0] conflict_cnt_o
);
    typedef enum logic [1:0] {OWN_NONE, OWN_TS, OWN_DAT, OWN_DMA} owner_e;

    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic            rr_q, rr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ts_act;
    logic [7:0]      be_sel;

    // TS-map always wins; dat/dma share the rest round-robin, and the port follows the winner
    always_comb begin
        ts_act      = !rst_i && ts_cs_i;
        dat_gnt_o   = !rst_i && !ts_cs_i && dat_req_i && (!dma_req_i || !rr_q);
        dma_gnt_o   = !rst_i && !ts_cs_i && dma_req_i && (!dat_req_i || rr_q);
        mem_cs_o    = ts_act || dat_gnt_o || dma_gnt_o;
        mem_we_o    = dat_gnt_o ? dat_we_i : dma_gnt_o ? dma_we_i : 1'b0;
        be_sel      = dat_gnt_o ? dat_be_i : dma_gnt_o ? dma_be_i : 8'h0;
        mem_wmask_o = mem_we_o ? {|be_sel, be_sel} : 9'h0;
        mem_addr_o  = ts_act ? ts_addr_i : dat_gnt_o ? dat_addr_i : dma_gnt_o ? dma_addr_i : '0;
        mem_wdata_o = dat_gnt_o ? dat_wdata_i : dma_gnt_o ? dma_wdata_i : 65'h0;
        owner_d     = ts_act ? OWN_TS : dat_gnt_o ? OWN_DAT : dma_gnt_o ? OWN_DMA : OWN_NONE;
        we_d        = mem_we_o;
        rr_d        = dat_gnt_o ? 1'b1 : dma_gnt_o ? 1'b0 : rr_q;
        cnt_d       = (ts_cs_i && (dat_req_i || dma_req_i) && !(&cnt_q)) ? cnt_q + CntW'(1) : cnt_q;
    end

    // Route the SRAM read data to whoever owned last cycle's access; writes answer with zero data
    always_comb begin
        dat_rvalid_o   = owner_q == OWN_DAT;
        dma_rvalid_o   = owner_q == OWN_DMA;
        dat_rdata_o    = (dat_rvalid_o && !we_q) ? mem_rdata_i : 65'h0;
        dma_rdata_o    = (dma_rvalid_o && !we_q) ? mem_rdata_i : 65'h0;
        ts_rdata_o     = (owner_q == OWN_TS) ? mem_rdata_i : 65'h0;
        conflict_cnt_o = cnt_q;
    end

    // Arbiter state: round-robin pointer, response owner, and saturating conflict counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q    <= 1'b0;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/cheri_dram_arbiter.md
CHERI_DRAM_ARBITER -- requirements
Module: cheri_dram_arbiter

Interface
- REQ-001: Parameter AW, default 14, SRAM word-address width (64-bit words).
- REQ-002: Parameter CntW, default 16, width of the conflict counter.
- REQ-003: clk_i  input  1  single clock; all state on rising edge.
- REQ-004: rst_i  input  1  reset, asynchronous and active-high.
- REQ-005: dat_req_i / dat_gnt_o  in/out  1/1  core data port request and grant.
- REQ-006: dat_we_i, dat_be_i, dat_addr_i, dat_wdata_i  input  1/8/AW/65  write enable, byte enables, word address, write data (bit 64 = tag).
- REQ-007: dat_rvalid_o, dat_rdata_o  output  1/65  core data response.
- REQ-008: dma_req_i, dma_gnt_o, dma_we_i, dma_be_i, dma_addr_i, dma_wdata_i, dma_rvalid_o, dma_rdata_o  same widths and meanings as the dat_* ports, for the DMA requester.
- REQ-009: ts_cs_i, ts_addr_i  input  1/AW  TS-map read strobe and word address; cannot be stalled.
- REQ-010: ts_rdata_o  output  65  TS-map read data.
- REQ-011: mem_cs_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o  output  1/1/9/AW/65  single-port SRAM controls.
- REQ-012: mem_rdata_i  input  65  SRAM read data, valid one cycle after a read.
- REQ-013: conflict_cnt_o  output  CntW  saturating count of cycles in which dat or dma was blocked by TS-map.

Function
- REQ-014: Priority is fixed: ts_cs_i beats dat and dma; when ts_cs_i=1, dat_gnt_o=dma_gnt_o=0.
- REQ-015: Arbitration between dat and dma is round-robin, using a 1-bit pointer rr_q (0 = dat favoured, 1 = dma favoured).
- REQ-016: If only one of dat and dma requests and ts_cs_i=0, that requester is granted in the same cycle.
- REQ-017: If both request and ts_cs_i=0, the favoured requester is granted.
- REQ-018: After a dat grant, rr_q becomes 1; after a dma grant, rr_q becomes 0; without a grant, rr_q holds.
- REQ-019: Grants are combinational from the requests and the current state; at most one grant is asserted per cycle.
- REQ-020: mem_cs_o=1 in any cycle with ts_cs_i=1 or a grant, else 0.
- REQ-021: The mem_* outputs mirror the winner in the same cycle; TS-map accesses are always reads (mem_we_o=0).
- REQ-022: mem_wmask_o = {|be, be} on writes and 9'h0 on reads; mem_addr_o and mem_wdata_o are 0 when mem_cs_o=0.
- REQ-023: An owner tag (none/ts/dat/dma) and a we bit are registered at each access.
- REQ-024: In the following cycle, exactly the owner's response is driven: ts_rdata_o = mem_rdata_i, or {dat,dma}_rvalid_o=1 with rdata = mem_rdata_i for a read and 65'h0 for a write.
- REQ-025: Read and write latency is exactly 1 cycle from grant to rvalid; back-to-back grants give back-to-back rvalids.
- REQ-026: Non-owner rdata outputs are 65'h0; ts_rdata_o is 65'h0 when the previous cycle was not a TS-map access.
- REQ-027: conflict_cnt_o increments by 1 in any cycle with ts_cs_i=1 and (dat_req_i or dma_req_i).
- REQ-028: conflict_cnt_o saturates at all-ones and does not wrap.
- REQ-029: Requesters hold req and attributes until granted; the arbiter does not latch ungranted requests.
- REQ-030: A request deasserted before grant is dropped silently.

Reset
- REQ-031: While rst_i=1: rr_q=0, owner tag = none, conflict_cnt_o=0, all rvalid outputs 0, all rdata outputs 65'h0.
- REQ-032: Grants and mem_cs_o are 0 during reset regardless of requests.
- REQ-033: A response pending when reset asserts is discarded; no rvalid appears after reset release without a new grant.
- REQ-034: The first cycle after release arbitrates normally with dat favoured.

Verification
- REQ-035: dat_req_i=1, read, addr=0x10, mem_rdata_i=65'h1_DEAD_BEEF_0000_0001 -> dat_gnt_o=1 in cycle T, mem_cs_o=1, mem_addr_o=0x10; dat_rvalid_o=1 in T+1 with that data.
- REQ-036: dat and dma both request for 4 cycles -> grant order dat, dma, dat, dma; rvalids follow one cycle later in the same order.
- REQ-037: ts_cs_i=1 for 3 cycles with dat_req_i=1 held -> dat_gnt_o=0 for those 3 cycles, conflict_cnt_o=3 afterwards; dat granted in the 4th cycle.
- REQ-038: dma write, be=8'h0F, wdata tag=1 -> mem_wmask_o=9'h10F, mem_we_o=1; dma_rvalid_o=1 next cycle with dma_rdata_o=65'h0.
- REQ-039: With CntW=4, hold ts_cs_i and dat_req_i for 20 cycles -> conflict_cnt_o stops at 4'hF.
- REQ-040: Assert rst_i in the cycle after a dat grant -> dat_rvalid_o=0 throughout and after reset; conflict_cnt_o=0; the next simultaneous dat/dma request grants dat.
